// File: rtl/alu16_seq.sv
// Two-pass 16-bit D-register sequencer (ADDD/SUBD/CMPD/LDD) over a shared 8-bit ALU.
// Low byte runs first; its carry feeds the high-byte pass, then the flags are merged.
module alu16_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic        cc_c_in,
  input  logic        cc_v_in,
  input  logic        cc_h_in,
  output logic        busy,
  output logic        done,
  output logic        result_we,
  output logic [15:0] result,
  output logic        c_out,
  output logic        v_out,
  output logic        z_out,
  output logic        n_out,
  output logic        h_out,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_op7,
  output logic        alu_c,
  output logic        alu_v,
  output logic        alu_h,
  input  logic [7:0]  alu_res,
  input  logic        alu_cf,
  input  logic        alu_zf,
  input  logic        alu_nf,
  input  logic        alu_vf
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  typedef enum logic [1:0] {ADD16 = 2'd0, SUB16 = 2'd1, CMP16 = 2'd2, LD16 = 2'd3} cmd_t;

  state_t      state, state_nxt;
  cmd_t        cmd_q;
  logic [15:0] opa_q, opb_q;
  logic        c_q, v_q, h_q;
  logic [7:0]  lo_res;
  logic        lo_c, lo_z;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      cmd_q  <= ADD16;
      opa_q  <= '0;
      opb_q  <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      h_q    <= 1'b0;
      lo_res <= '0;
      lo_c   <= 1'b0;
      lo_z   <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      v_out  <= 1'b0;
      z_out  <= 1'b0;
      n_out  <= 1'b0;
      h_out  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          cmd_q <= cmd_t'(cmd);
          opa_q <= opa;
          opb_q <= opb;
          c_q   <= cc_c_in;
          v_q   <= cc_v_in;
          h_q   <= cc_h_in;
        end
        LO: begin
          lo_res <= alu_res;
          lo_c   <= alu_cf;
          lo_z   <= alu_zf;
        end
        HI: begin
          result <= {alu_res, lo_res};
          n_out  <= alu_nf;
          z_out  <= lo_z & alu_zf;
          v_out  <= (cmd_q == LD16) ? 1'b0 : alu_vf;
          h_out  <= h_q;
          case (cmd_q)
            ADD16:   c_out <= alu_cf;
            LD16:    c_out <= c_q;
            default: c_out <= ~alu_cf;  // ALU reports not-borrow; CC wants borrow
          endcase
        end
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    alu_op7   = 1'b0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_h     = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LO;
      LO: begin
        state_nxt = HI;
        alu_a     = opa_q[7:0];
        alu_b     = opb_q[7:0];
        alu_op7   = 1'b1;
        alu_v     = v_q;
        alu_h     = h_q;
        case (cmd_q)
          ADD16:   alu_op = 4'hB;
          LD16:    begin alu_op = 4'h6; alu_c = c_q; end
          default: alu_op = 4'h0;
        endcase
      end
      HI: begin
        state_nxt = DONE;
        alu_a     = opa_q[15:8];
        alu_b     = opb_q[15:8];
        alu_op7   = 1'b1;
        alu_v     = v_q;
        alu_h     = h_q;
        case (cmd_q)
          ADD16:   begin alu_op = 4'h9; alu_c = lo_c; end
          LD16:    begin alu_op = 4'h6; alu_c = c_q; end
          default: begin alu_op = 4'h2; alu_c = ~lo_c; end  // sbc carry-in is borrow
        endcase
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == LO) || (state == HI);
  assign done      = (state == DONE);
  assign result_we = (state == DONE) && (cmd_q != CMP16);

endmodule

// File: tb/tb_alu16_seq.sv
// Directed bench for alu16_seq with a behavioural 6809-style 8-bit ALU closing the loop.
module tb_alu16_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  cmd;
  logic [15:0] opa, opb;
  logic        cc_c_in, cc_v_in, cc_h_in;
  logic        busy, done, result_we;
  logic [15:0] result;
  logic        c_out, v_out, z_out, n_out, h_out;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_op7, alu_c, alu_v, alu_h;
  logic [7:0]  alu_res;
  logic        alu_cf, alu_zf, alu_nf, alu_vf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu16_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .opa(opa), .opb(opb),
    .cc_c_in(cc_c_in), .cc_v_in(cc_v_in), .cc_h_in(cc_h_in),
    .busy(busy), .done(done), .result_we(result_we), .result(result),
    .c_out(c_out), .v_out(v_out), .z_out(z_out), .n_out(n_out), .h_out(h_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_op7(alu_op7),
    .alu_c(alu_c), .alu_v(alu_v), .alu_h(alu_h),
    .alu_res(alu_res), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_nf(alu_nf), .alu_vf(alu_vf)
  );

  // 8-bit ALU model: sub/sbc carry-out is not-borrow, sbc carry-in is borrow.
  logic [8:0] r9;
  always_comb begin
    r9     = '0;
    alu_cf = 1'b0;
    alu_vf = 1'b0;
    case (alu_op)
      4'hB: begin
        r9 = {1'b0, alu_a} + {1'b0, alu_b};
        alu_cf = r9[8];
        alu_vf = (alu_a[7] == alu_b[7]) && (r9[7] != alu_a[7]);
      end
      4'h9: begin
        r9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c};
        alu_cf = r9[8];
        alu_vf = (alu_a[7] == alu_b[7]) && (r9[7] != alu_a[7]);
      end
      4'h0: begin
        r9 = {1'b0, alu_a} - {1'b0, alu_b};
        alu_cf = ~r9[8];
        alu_vf = (alu_a[7] != alu_b[7]) && (r9[7] != alu_a[7]);
      end
      4'h2: begin
        r9 = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_c};
        alu_cf = ~r9[8];
        alu_vf = (alu_a[7] != alu_b[7]) && (r9[7] != alu_a[7]);
      end
      4'h6: begin
        r9 = {1'b0, alu_b};
        alu_cf = alu_c;
      end
      default: ;
    endcase
    alu_res = r9[7:0];
    alu_zf  = (r9[7:0] == 8'h00);
    alu_nf  = r9[7];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags packed as {c,v,z,n,h}
  task automatic run_op(input string tag, input logic [1:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic ci,
                        input logic [15:0] exp_res, input logic [4:0] exp_fl,
                        input logic exp_we);
    cmd = c; opa = a; opb = b; cc_c_in = ci; cc_v_in = 1'b0; cc_h_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_lo_busy"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, "_hi_done"}, {31'd0, done}, 32'd0);
    tick();
    check({tag, "_done"}, {30'd0, done, result_we}, {30'd0, 1'b1, exp_we});
    check({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    check({tag, "_flags"}, {27'd0, c_out, v_out, z_out, n_out, h_out}, {27'd0, exp_fl});
    tick();
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; cmd = '0; opa = '0; opb = '0;
    cc_c_in = 1'b0; cc_v_in = 1'b0; cc_h_in = 1'b0;
    tick(); tick();
    check("rst_ctl", {29'd0, busy, done, result_we}, 32'd0);
    check("rst_res", {16'd0, result}, 32'd0);
    check("rst_alu", {7'd0, alu_a, alu_b, alu_op, alu_op7, alu_c, alu_v, alu_h}, 32'd0);
    reset_n = 1'b1;
    tick();

    run_op("add_carry", 2'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 5'b00000, 1'b1);
    run_op("add_wrap",  2'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b10100, 1'b1);
    run_op("sub_neg",   2'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 5'b10010, 1'b1);
    run_op("sub_pos",   2'd1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 5'b00000, 1'b1);
    run_op("cmp_eq",    2'd2, 16'h1234, 16'h1234, 1'b0, 16'h0000, 5'b00100, 1'b0);
    run_op("ld_neg",    2'd3, 16'h8000, 16'h8000, 1'b1, 16'h8000, 5'b10010, 1'b1);
    // 0x7FFF + 1 overflows signed: V=1, N=1
    run_op("add_ovf",   2'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b01010, 1'b1);

    // ALU drive in each pass for an ADD16
    cmd = 2'd0; opa = 16'hA512; opb = 16'h3C07; cc_c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("drv_lo", {12'd0, alu_a, alu_b, alu_op}, {12'd0, 8'h12, 8'h07, 4'hB});
    tick();
    check("drv_hi", {11'd0, alu_a, alu_b, alu_op, alu_c}, {11'd0, 8'hA5, 8'h3C, 4'h9, 1'b0});
    tick();
    check("drv_done_zero", {12'd0, alu_a, alu_b, alu_op}, 32'd0);
    tick();

    // start held high: accepts every 4th cycle
    cmd = 2'd0; opa = 16'h0001; opb = 16'h0001; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("hold_%0d", i), {30'd0, busy, done},
            {30'd0, (i % 4) < 2, (i % 4) == 2});
    end
    start = 1'b0;
    tick();

    // start pulses during LO/HI/DONE are ignored
    cmd = 2'd0; opa = 16'h00FF; opb = 16'h0001; start = 1'b1;
    tick();
    cmd = 2'd1; opa = 16'hFFFF; opb = 16'h1111;
    tick();
    check("ign_hi_a", {24'd0, alu_a}, 32'h00);
    tick();
    check("ign_result", {16'd0, result}, 32'h0100);
    start = 1'b0;
    tick();
    check("ign_idle", {30'd0, busy, done}, 32'd0);

    // reset during HI aborts
    cmd = 2'd0; opa = 16'h1111; opb = 16'h2222; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("abort_ctl", {29'd0, busy, done, result_we}, 32'd0);
    check("abort_res", {11'd0, result, c_out, v_out, z_out, n_out, h_out}, 32'd0);
    check("abort_alu", {7'd0, alu_a, alu_b, alu_op, alu_op7, alu_c, alu_v, alu_h}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("abort_nodone", {31'd0, done}, 32'd0);
    run_op("post_rst", 2'd0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 5'b00000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu16_seq.md
# alu16_seq

Two-pass sequencer that executes the 6809 16-bit D-register operations (ADDD, SUBD, CMPD, LDD flag test) on the shared 8-bit ALU. It splits each operation into a low-byte pass and a high-byte pass and chains the carry between them. It then merges the per-pass flags into 16-bit condition codes. It sits between the execute-stage control and the `alu8` instance: it owns the ALU operand and opcode inputs while busy, and drives them to zero while idle.

## Interface
Parameters: none.
- `clk`  in  1  core clock; all state updates on rising edge
- `reset_n`  in  1  synchronous, active-low reset, sampled on rising edge of `clk`
- `start`  in  1  request; accepted only in IDLE
- `cmd`  in  2  0=ADD16, 1=SUB16, 2=CMP16, 3=LD16; sampled with `start`
- `opa`  in  16  left operand (D); sampled with `start`
- `opb`  in  16  right operand (memory/immediate); sampled with `start`
- `cc_c_in`, `cc_v_in`, `cc_h_in`  in  1 each  current C/V/H; sampled with `start`
- `busy`  out  1  high in LO and HI states
- `done`  out  1  one-cycle pulse in DONE state
- `result_we`  out  1  pulse with `done`; 1 for ADD16/SUB16/LD16, 0 for CMP16
- `result`  out  16  16-bit result; holds until the next accepted `start`
- `c_out`, `v_out`, `z_out`, `n_out`, `h_out`  out  1 each  merged flags; hold with `result`
- `alu_a`, `alu_b`  out  8 each  to `alu8` `alu_in_a`/`alu_in_b`
- `alu_op`  out  4  to `alu8` `op`
- `alu_op7`  out  1  to `alu8` `op7`
- `alu_c`, `alu_v`, `alu_h`  out  1 each  to `alu8` `c_in`/`v_in`/`h_in`
- `alu_res`  in  8  from `alu8` `alu_out`
- `alu_cf`, `alu_zf`, `alu_nf`, `alu_vf`  in  1 each  from `alu8` `c_out`/`z_out`/`n_out`/`v_out`

## Operation
- States: IDLE, LO, HI, DONE. Transitions:
  - IDLE→LO on `start`.
  - LO→HI unconditionally.
  - HI→DONE unconditionally.
  - DONE→IDLE unconditionally.
- `start` is ignored in LO, HI and DONE. There is no queuing.
- On acceptance, latch `cmd`, `opa`, `opb`, `cc_c_in`, `cc_v_in` and `cc_h_in`.
- ALU drive in the LO pass uses `alu_a`=opa[7:0] and `alu_b`=opb[7:0]:
  - ADD16: op=4'hB, op7=1, `alu_c`=0.
  - SUB16/CMP16: op=4'h0, op7=1 (sub), `alu_c`=0.
  - LD16: op=4'h6, op7=1 (ld), `alu_c`=latched C.
- ALU drive in the HI pass uses `alu_a`=opa[15:8] and `alu_b`=opb[15:8]. The LO-pass carry is `lo_c`:
  - ADD16: op=4'h9, op7=1 (adc), `alu_c`=`lo_c`.
  - SUB16/CMP16: op=4'h2 (sbc), `alu_c`=~`lo_c`. The ALU's sub carry means not-borrow, while its sbc carry-in means borrow.
  - LD16: op=4'h6, op7=1, `alu_c`=latched C.
- `alu_v`=latched V and `alu_h`=latched H in both passes.
- IDLE and DONE drive all `alu_*` outputs to 0.
- At the end of LO, register `lo_res`←`alu_res`, `lo_c`←`alu_cf` and `lo_z`←`alu_zf`.
- At the end of HI, register the following:
  - `result`←{`alu_res`, `lo_res`}.
  - `n_out`←`alu_nf`.
  - `z_out`←`lo_z` & `alu_zf`.
  - `v_out`←`alu_vf` (0 for LD16).
  - `c_out`←~`alu_cf` for SUB16/CMP16, `alu_cf` for ADD16, latched C for LD16.
  - `h_out`←latched H (H is not defined for 16-bit operations).
- CMP16 updates `result` and the flags, but `result_we` stays 0.

## Timing
- Reset (`reset_n`=0 at an edge) does the following:
  - Moves to IDLE.
  - Clears `busy`, `done`, `result_we`, `result`, all flag outputs and all latches.
  - Forces `alu_*` outputs to 0 in the same cycle.
- Reset mid-operation (LO/HI/DONE) aborts with no `done` pulse.
- Latency: `start` high at edge k (IDLE) gives LO in cycle k+1, HI in k+2, and `done`/`result_we` high in k+3 only.
- `result` and the flags are valid from the cycle `done` is high and hold until the edge after the next accepted `start`'s HI pass.
- Back-to-back: the earliest next accept is the edge ending DONE+1 (IDLE), so there are 4 cycles per operation minimum.
- The ALU path is combinational: `alu_*` outputs depend only on state and latches, with no input-to-output paths.
- All arithmetic is mod 2^16. There is no overflow trap; the carry is reported only via `c_out`.

## Test plan
- ADD16 opa=0x00FF, opb=0x0001 -> `done` at k+3, `result`=0x0100, C=0, Z=0, N=0, `result_we`=1.
- ADD16 0xFFFF+0x0001 -> `result`=0x0000, C=1, Z=1 (checks Z merge and carry chain).
- SUB16 0x0000-0x0001 -> `result`=0xFFFF, C=1, N=1, Z=0; SUB16 0x0005-0x0003 -> 0x0002, C=0.
- CMP16 0x1234 vs 0x1234 -> Z=1, C=0, `result_we`=0. LD16 opa=0x8000 with `cc_c_in`=1 -> N=1, Z=0, V=0, C=1.
- `start` held high continuously -> accepts exactly every 4th cycle. `start` pulsed during LO/HI/DONE -> ignored, and the latched operands stay unchanged.
- `reset_n` low during HI -> no `done`, all outputs 0 next cycle, and a following ADD16 completes correctly.
